// File: rtl/serial_link_port_pkg.sv
// ------------------------------------------------------------------
// gb_serial_pkg : shared constants and state encoding for the serial port
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package gb_serial_pkg;

  localparam int          CLK_DIV_DEF = 512;
  localparam logic [15:0] SB_ADDR_DEF = 16'hFF01;
  localparam logic [15:0] SC_ADDR_DEF = 16'hFF02;

  localparam int          SC_START    = 7;
  localparam int          SC_CLKSEL   = 0;
  localparam logic [7:0]  SC_RD_MASK  = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT_INT = 2'd1,
    ST_SHIFT_EXT = 2'd2
  } serial_state_e;

  function automatic logic [7:0] sc_read_value(input logic start, input logic clksel);
    logic [7:0] v;
    v = SC_RD_MASK;
    v[SC_START]  = start;
    v[SC_CLKSEL] = clksel;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_link_port_if.sv
// ------------------------------------------------------------------
// serial_link_port_if : CPU address/data/strobe bus seen by the serial port
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

interface serial_link_port_if;
  logic [15:0] addr_bus;
  logic [7:0]  data_in;
  logic        rd;
  logic        wr;
  logic [7:0]  data_out;
  logic        hit;

  modport master (
    output addr_bus, data_in, rd, wr,
    input  data_out, hit
  );

  modport slave (
    input  addr_bus, data_in, rd, wr,
    output data_out, hit
  );
endinterface

`default_nettype wire

// File: rtl/serial_link_port_clkgen.sv
// ------------------------------------------------------------------
// serial_clkgen : internal serial clock divider plus external clock edge detect
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module serial_clkgen
  import gb_serial_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire serial_state_e i_state,
  input  wire logic          i_enable,
  input  wire logic          i_restart,
  input  wire logic          i_sclk_in,
  output logic               o_sclk_out,
  output logic               o_rise_pulse,
  output logic               o_fall_pulse
);

  localparam int            DW        = $clog2(CLK_DIV);
  localparam logic [DW-1:0] c_half_m1 = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] c_half    = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0] c_last    = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div_cnt;
  logic [DW-1:0] w_div_inc;
  logic          r_sclk_out;
  logic [2:0]    r_sync;
  logic          w_ext_rise;
  logic          w_ext_fall;

  assign w_div_inc = (r_div_cnt == c_last) ? '0 : r_div_cnt + 1'b1;

  // r_sync[1:0] is the synchronizer; r_sync[2] is the history flop for edge detect
  assign w_ext_rise =  r_sync[1] & ~r_sync[2];
  assign w_ext_fall = ~r_sync[1] &  r_sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_sclk_out <= 1'b1;
      r_sync     <= 3'b111;
    end else begin
      r_sync <= {r_sync[1:0], i_sclk_in};
      if (!i_enable) begin
        r_div_cnt  <= '0;
        r_sclk_out <= 1'b1;
      end else if (i_restart) begin
        r_div_cnt  <= '0;
        r_sclk_out <= 1'b0;
      end else begin
        r_div_cnt  <= w_div_inc;
        r_sclk_out <= (w_div_inc >= c_half);
      end
    end
  end

  always_comb begin
    o_rise_pulse = 1'b0;
    o_fall_pulse = 1'b0;
    case (i_state)
      ST_SHIFT_INT: begin
        o_rise_pulse = (r_div_cnt == c_half_m1);
        o_fall_pulse = (r_div_cnt == c_last);
      end
      ST_SHIFT_EXT: begin
        o_rise_pulse = w_ext_rise;
        o_fall_pulse = w_ext_fall;
      end
      default: ;
    endcase
  end

  assign o_sclk_out = r_sclk_out;

endmodule

`default_nettype wire

// File: rtl/serial_link_port.sv
// ------------------------------------------------------------------
// serial_link_port : SB/SC mapped 8-bit MSB-first serial link with interrupt
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module serial_link_port
  import gb_serial_pkg::*;
#(
  parameter int          CLK_DIV = CLK_DIV_DEF,
  parameter logic [15:0] SB_ADDR = SB_ADDR_DEF,
  parameter logic [15:0] SC_ADDR = SC_ADDR_DEF
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  serial_link_port_if.slave bus,
  output logic              sclk_out,
  output logic              sclk_oe,
  input  wire logic         sclk_in,
  output logic              sout,
  input  wire logic         sin,
  output logic              irq,
  input  wire logic         irq_ack
);

  serial_state_e w_state;

  logic [7:0] r_sb;
  logic       r_start;
  logic       r_clksel;
  logic [3:0] r_bit_cnt;
  logic       r_sout;
  logic       r_irq;

  logic       w_sel_sb, w_sel_sc, w_sb_wr, w_sc_wr;
  logic       w_rise, w_fall, w_drive, w_done;
  logic       w_begin, w_abort, w_restart;
  logic       w_next_start, w_next_clksel, w_int_next;
  logic [7:0] w_sb_next;

  always_comb begin
    w_state = ST_IDLE;
    if (r_start) w_state = r_clksel ? ST_SHIFT_INT : ST_SHIFT_EXT;
  end

  assign w_sel_sb = (bus.addr_bus == SB_ADDR);
  assign w_sel_sc = (bus.addr_bus == SC_ADDR);
  assign w_sb_wr  = bus.wr & w_sel_sb;
  assign w_sc_wr  = bus.wr & w_sel_sc;

  // Internal mode only drives on falls that sit between two samples
  assign w_drive = w_fall & ((w_state == ST_SHIFT_EXT) |
                             ((r_bit_cnt != 4'd0) && (r_bit_cnt < 4'd8)));
  assign w_done  = w_rise & (r_bit_cnt == 4'd7);

  assign w_sb_next = w_rise                ? {r_sb[6:0], sin} :
                     (w_sb_wr && !r_start) ? bus.data_in      : r_sb;

  // CPU write to SC overrides completion for start/clksel
  assign w_next_start  = w_sc_wr ? bus.data_in[SC_START]  : (w_done ? 1'b0 : r_start);
  assign w_next_clksel = w_sc_wr ? bus.data_in[SC_CLKSEL] : r_clksel;
  assign w_int_next    = w_next_start & w_next_clksel;

  assign w_begin   = w_sc_wr & bus.data_in[SC_START] & (~r_start | w_done);
  assign w_abort   = w_sc_wr & ~bus.data_in[SC_START] & r_start;
  assign w_restart = w_begin |
                     (w_sc_wr & r_start & bus.data_in[SC_START] &
                      (bus.data_in[SC_CLKSEL] != r_clksel));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb      <= 8'h00;
      r_start   <= 1'b0;
      r_clksel  <= 1'b0;
      r_bit_cnt <= 4'd0;
      r_sout    <= 1'b1;
      r_irq     <= 1'b0;
    end else begin
      r_sb     <= w_sb_next;
      r_start  <= w_next_start;
      r_clksel <= w_next_clksel;

      if (w_begin || w_abort || w_done) r_bit_cnt <= 4'd0;
      else if (w_rise)                  r_bit_cnt <= r_bit_cnt + 4'd1;

      if (w_begin)      r_sout <= w_sb_next[7];
      else if (w_drive) r_sout <= r_sb[7];

      if (w_done)       r_irq <= 1'b1;
      else if (irq_ack) r_irq <= 1'b0;
    end
  end

  serial_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_state      (w_state),
    .i_enable     (w_int_next),
    .i_restart    (w_restart),
    .i_sclk_in    (sclk_in),
    .o_sclk_out   (sclk_out),
    .o_rise_pulse (w_rise),
    .o_fall_pulse (w_fall)
  );

  assign bus.hit      = bus.rd & (w_sel_sb | w_sel_sc);
  assign bus.data_out = !bus.hit ? 8'hFF :
                        w_sel_sb ? r_sb  : sc_read_value(r_start, r_clksel);

  assign sclk_oe = r_clksel;
  assign sout    = r_sout;
  assign irq     = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_serial_link_port.sv
// ------------------------------------------------------------------
// tb_serial_link_port : directed vector bench for serial_link_port
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_serial_link_port;

  localparam logic [15:0] c_sb = 16'hFF01;
  localparam logic [15:0] c_sc = 16'hFF02;

  logic clk = 1'b0;
  logic rst_n;
  logic sclk_in, sin, irq_ack;
  logic sclk_out, sclk_oe, sout, irq;

  int n_vec = 0;
  int n_err = 0;
  logic in_ext = 1'b0;
  logic oe_bad = 1'b0;

  serial_link_port_if bus ();

  serial_link_port dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .sclk_out (sclk_out),
    .sclk_oe  (sclk_oe),
    .sclk_in  (sclk_in),
    .sout     (sout),
    .sin      (sin),
    .irq      (irq),
    .irq_ack  (irq_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (in_ext && sclk_oe) oe_bad = 1'b1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        do_wr;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd;
    logic [15:0] rd_addr;
    logic        exp_hit;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr_bus = a;
    bus.data_in  = d;
    bus.wr       = 1'b1;
    @(negedge clk);
    bus.wr       = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, input logic r, output logic h, output logic [7:0] d);
    bus.addr_bus = a;
    bus.rd       = r;
    #1;
    h = bus.hit;
    d = bus.data_out;
    bus.rd = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [15:0] a, input logic [7:0] exp);
    logic h;
    logic [7:0] d;
    do_read(a, 1'b1, h, d);
    check(name, d, exp);
  endtask

  task automatic ack_irq();
    @(negedge clk);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  // Steps from the negedge after a start write until irq rises
  task automatic run_xfer(input int sbwr_cyc, input int ack_cyc, input bit chk_bits,
                          input logic [7:0] exp_bits, output int irq_at, output int nfall);
    logic prev;
    prev   = 1'b1;
    irq_at = -1;
    nfall  = 0;
    for (int c = 0; c < 5000 && irq_at < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (prev && !sclk_out) begin
        if (chk_bits && nfall < 8) check("int_sout_bit", sout, exp_bits[7-nfall]);
        nfall++;
      end
      prev = sclk_out;
      if (irq) irq_at = c;
      if (c == sbwr_cyc) begin
        bus.addr_bus = c_sb;
        bus.data_in  = 8'hFF;
        bus.wr       = 1'b1;
      end
      if (c == sbwr_cyc + 1) bus.wr = 1'b0;
      if (c == ack_cyc) irq_ack = 1'b1;
    end
  endtask

  initial begin
    logic        h;
    logic [7:0]  d;
    logic [7:0]  ext_bits;
    int          irq_at, nfall;

    vecs[0] = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'hFF01, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'hFF02, 1'b1, 8'h7E};
    vecs[2] = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'hFF03, 1'b0, 8'hFF};
    vecs[3] = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'hFF00, 1'b0, 8'hFF};
    vecs[4] = '{1'b0, 16'h0000, 8'h00, 1'b0, 16'hFF01, 1'b0, 8'hFF};
    vecs[5] = '{1'b1, 16'hFF01, 8'h5A, 1'b1, 16'hFF01, 1'b1, 8'h5A};
    vecs[6] = '{1'b1, 16'hFF02, 8'h01, 1'b1, 16'hFF02, 1'b1, 8'h7F};
    vecs[7] = '{1'b1, 16'hFF02, 8'h7E, 1'b1, 16'hFF02, 1'b1, 8'h7E};
    vecs[8] = '{1'b1, 16'hFF01, 8'hA5, 1'b1, 16'hFF01, 1'b1, 8'hA5};
    vecs[9] = '{1'b1, 16'hFF03, 8'h00, 1'b1, 16'hFF01, 1'b1, 8'hA5};

    rst_n        = 1'b0;
    sclk_in      = 1'b1;
    sin          = 1'b0;
    irq_ack      = 1'b0;
    bus.addr_bus = 16'h0000;
    bus.data_in  = 8'h00;
    bus.rd       = 1'b0;
    bus.wr       = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_sclk_oe", sclk_oe, 1'b0);
    check("rst_sout", sout, 1'b1);
    check("rst_irq", irq, 1'b0);
    check("rst_sclk_out", sclk_out, 1'b1);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) cpu_write(vecs[i].wr_addr, vecs[i].wr_data);
      do_read(vecs[i].rd_addr, vecs[i].rd, h, d);
      check($sformatf("vec%0d_hit", i), h, vecs[i].exp_hit);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
    end

    // Internal transfer of A5 with sin held low
    sin = 1'b0;
    cpu_write(c_sc, 8'h81);
    run_xfer(-10, -10, 1'b1, 8'hA5, irq_at, nfall);
    check("int_irq_cycle", irq_at, 3840);
    check("int_fall_count", nfall, 8);
    check_reg("int_sb_final", c_sb, 8'h00);
    check_reg("int_sc_final", c_sc, 8'h7F);
    ack_irq();
    check("int_irq_cleared", irq, 1'b0);

    // External transfer of 3C, shifting in CA
    cpu_write(c_sb, 8'h3C);
    cpu_write(c_sc, 8'h80);
    in_ext   = 1'b1;
    ext_bits = 8'b1100_1010;
    for (int i = 0; i < 8; i++) begin
      sclk_in = 1'b0;
      sin     = ext_bits[7-i];
      repeat (20) @(negedge clk);
      sclk_in = 1'b1;
      if (i < 7) repeat (20) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("ext_irq_early", irq, 1'b0);
    @(negedge clk);
    check("ext_irq", irq, 1'b1);
    check_reg("ext_sb_final", c_sb, 8'hCA);
    check_reg("ext_sc_final", c_sc, 8'h7E);
    in_ext = 1'b0;
    check("ext_sclk_oe_low", oe_bad, 1'b0);
    ack_irq();

    // Abort after three samples, then a full fresh transfer with a blocked SB write
    cpu_write(c_sb, 8'hF0);
    sin = 1'b1;
    cpu_write(c_sc, 8'h81);
    repeat (1400) @(negedge clk);
    cpu_write(c_sc, 8'h01);
    check_reg("abort_sb_partial", c_sb, 8'h87);
    check_reg("abort_sc", c_sc, 8'h7F);
    check("abort_sclk_out", sclk_out, 1'b1);
    repeat (600) @(negedge clk);
    check("abort_no_irq", irq, 1'b0);
    sin = 1'b0;
    cpu_write(c_sc, 8'h81);
    run_xfer(1000, -10, 1'b0, 8'h00, irq_at, nfall);
    check("restart_irq_cycle", irq_at, 3840);
    check_reg("wprot_sb_final", c_sb, 8'h00);
    ack_irq();

    // irq_ack held across the completion edge and the one after
    cpu_write(c_sc, 8'h81);
    run_xfer(-10, 3839, 1'b0, 8'h00, irq_at, nfall);
    check("collide_irq_cycle", irq_at, 3840);
    check("collide_irq_set", irq, 1'b1);
    @(negedge clk);
    irq_ack = 1'b0;
    check("collide_irq_ack", irq, 1'b0);

    // Asynchronous reset in the middle of a transfer
    cpu_write(c_sb, 8'h96);
    cpu_write(c_sc, 8'h81);
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sclk_out", sclk_out, 1'b1);
    check("arst_sout", sout, 1'b1);
    check("arst_sclk_oe", sclk_oe, 1'b0);
    check_reg("arst_sb", c_sb, 8'h00);
    check_reg("arst_sc", c_sc, 8'h7E);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
